// File: rtl/isqrt_iter_fsm.sv
// isqrt_iter_fsm: floor(sqrt(x)) of an N-bit unsigned operand, restoring digit-by-digit, two operand bits per cycle.
// Latency: x_vld accepted in cycle t -> y_vld in cycle t+N/2+1, independent of operand value.
// Backpressure: none; x_vld is ignored while busy=1, and a new operand may be accepted in the y_vld (DONE) cycle.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   x_vld  - single-cycle start pulse, x sampled when accepted (IDLE or DONE)
//   x      - N-bit unsigned operand
//   y_vld  - single-cycle result-valid pulse
//   y      - N/2-bit result, held until the next result
//   busy   - high during all iteration cycles
module isqrt_iter_fsm #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_vld,
  input  logic [N-1:0]     x,
  output logic             y_vld,
  output logic [N/2-1:0]   y,
  output logic             busy
);

  localparam int H  = N / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  op_q,    op_d;
  logic [H+1:0]  rem_q,   rem_d;
  logic [H-1:0]  root_q,  root_d;
  logic [H-1:0]  y_q,     y_d;

  // One restoring step: bring down the next two operand bits, try to
  // subtract 4*root+1, and shift the resulting root digit in.
  logic [H+1:0] rem_sh;
  logic [H+1:0] trial;
  logic         take;
  logic [H+1:0] rem_nx;
  logic [H-1:0] root_nx;

  always_comb begin
    rem_sh  = (rem_q << 2) | {{H{1'b0}}, op_q[N-1:N-2]};
    trial   = {root_q, 2'b01};
    take    = (rem_sh >= trial);
    rem_nx  = take ? (rem_sh - trial) : rem_sh;
    root_nx = (root_q << 1) | {{(H-1){1'b0}}, take};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (x_vld) begin
          op_d    = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        op_d   = op_q << 2;
        rem_d  = rem_nx;
        root_d = root_nx;
        if (cnt_q == CW'(H - 1)) begin
          y_d     = root_nx;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // Accepting here gives back-to-back throughput of one result per H+1 cycles.
        if (x_vld) begin
          op_d    = x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      y_q     <= y_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign y_vld = (state_q == S_DONE);
  assign busy  = (state_q == S_CALC);
  assign y     = y_q;

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
module tb_isqrt_iter_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        xa_vld, xb_vld, xc_vld;
  logic [31:0] xa, xb;
  logic [7:0]  xc;
  logic        ya_vld, yb_vld, yc_vld;
  logic [15:0] ya, yb;
  logic [3:0]  yc;
  logic        busy_a, busy_b, busy_c;

  isqrt_iter_fsm #(.N(32)) u_a (
    .clk(clk), .rst_n(rst_n), .x_vld(xa_vld), .x(xa),
    .y_vld(ya_vld), .y(ya), .busy(busy_a)
  );
  isqrt_iter_fsm #(.N(32)) u_b (
    .clk(clk), .rst_n(rst_n), .x_vld(xb_vld), .x(xb),
    .y_vld(yb_vld), .y(yb), .busy(busy_b)
  );
  isqrt_iter_fsm #(.N(8)) u_c (
    .clk(clk), .rst_n(rst_n), .x_vld(xc_vld), .x(xc),
    .y_vld(yc_vld), .y(yc), .busy(busy_c)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
  endtask

  // Independent reference: greedy bit-by-bit search for the largest r with r*r <= v.
  function automatic logic [31:0] ref_sqrt(input logic [63:0] v);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[31:0];
  endfunction

  // Monitor: pops the scoreboard whenever a DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (ya_vld) begin
      check("a_vld_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_y", ya, e.y);
        check("a_latency", cyc, e.cyc);
      end
    end
    if (yb_vld) begin
      check("b_vld_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_y", yb, e.y);
        check("b_latency", cyc, e.cyc);
      end
    end
    if (yc_vld) begin
      check("c_vld_expected", qc.size() != 0, 1);
      if (qc.size() != 0) begin
        e = qc.pop_front();
        check("c_y", yc, e.y);
        check("c_latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; drives a one-cycle start pulse.
  task automatic start_a(input logic [31:0] v, input logic [31:0] want, input bit push);
    xa_vld = 1'b1;
    xa     = v;
    if (push) qa.push_back('{want, cyc + 17});
    @(posedge clk);
    #1;
    xa_vld = 1'b0;
  endtask

  task automatic start_c(input logic [7:0] v);
    xc_vld = 1'b1;
    xc     = v;
    qc.push_back('{ref_sqrt({56'd0, v}), cyc + 5});
    @(posedge clk);
    #1;
    xc_vld = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] dx [0:7];
  logic [31:0] dy [0:7];

  initial begin
    int k;
    logic [31:0] rv;
    dx = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000, 32'd99};
    dy = '{32'd0, 32'd1, 32'd3,  32'd4,  32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 32'd9};

    rst_n  = 1'b0;
    xa_vld = 1'b0; xb_vld = 1'b0; xc_vld = 1'b0;
    xa = '0; xb = '0; xc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y", ya, 0);
    check("rst_y_vld", ya_vld, 0);
    check("rst_busy", busy_a, 0);
    check("rst_c_y", yc, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Directed single operands, each started from IDLE.
    for (int i = 0; i < 8; i++) begin
      start_a(dx[i], dy[i], 1'b1);
      wait_cycles(18);
    end

    // Two instances started together finish together.
    xa_vld = 1'b1; xa = 32'd9;
    xb_vld = 1'b1; xb = 32'd1000000;
    qa.push_back('{32'd3, cyc + 17});
    qb.push_back('{32'd1000, cyc + 17});
    @(posedge clk);
    #1;
    xa_vld = 1'b0; xb_vld = 1'b0;
    wait_cycles(18);

    // Start pulse in CALC cycle 5 must be ignored.
    start_a(32'd100, 32'd10, 1'b1);
    wait_cycles(4);
    check("ign_busy", busy_a, 1);
    xa_vld = 1'b1; xa = 32'd4;
    @(posedge clk);
    #1;
    xa_vld = 1'b0;
    wait_cycles(30);

    // Back-to-back: second operand accepted in the DONE cycle.
    k = cyc;
    xa_vld = 1'b1; xa = 32'd49;
    qa.push_back('{32'd7, k + 17});
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      #1;
      xa_vld = (i == 17);
      if (i == 17) begin
        xa = 32'd81;
        qa.push_back('{32'd9, cyc + 17});
      end
      check("b2b_busy", busy_a, ((i >= 1 && i <= 16) || (i >= 18 && i <= 33)) ? 1 : 0);
    end
    wait_cycles(3);

    // Reset in CALC cycle 8 aborts the operation.
    start_a(32'd1000000, 32'd1000, 1'b1);
    wait_cycles(7);
    check("pre_rst_busy", busy_a, 1);
    rst_n = 1'b0;
    qa.delete();
    #1;
    check("abort_y", ya, 0);
    check("abort_y_vld", ya_vld, 0);
    check("abort_busy", busy_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(25);
    start_a(32'd144, 32'd12, 1'b1);
    wait_cycles(18);

    // N=8 exhaustive, back-to-back through the DONE cycle.
    for (int v = 0; v < 256; v++) begin
      start_c(v[7:0]);
      wait_cycles(4);
    end
    wait_cycles(8);

    // Random 32-bit operands against the reference, back-to-back.
    for (int i = 0; i < 2000; i++) begin
      rv = $urandom;
      if (i % 4 == 0) rv = rv >> $urandom_range(0, 31);
      start_a(rv, ref_sqrt({32'd0, rv}), 1'b1);
      wait_cycles(16);
    end
    wait_cycles(20);

    check("a_drained", qa.size(), 0);
    check("b_drained", qb.size(), 0);
    check("c_drained", qc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
